// File: rtl/cvp14_mem_responder.sv
// Memory-side responder for the CVP14 bus: word-addressed RAM serviced after LATENCY wait
// states, with a one-cycle Ready/Err completion pulse.
module cvp14_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Ready,
  output logic        Err,
  output logic        Busy
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic        rd_q;
  logic        wr_q;
  logic [15:0] ram [Words];

  logic                  accept;
  logic                  commit;
  logic [15:0]           c_addr;
  logic [15:0]           c_data;
  logic                  c_rd;
  logic                  c_wr;
  logic                  c_err;
  logic [DEPTH_LOG2-1:0] c_idx;

  always_comb begin
    accept = (state_q == StIdle) && (RD || WR);
    // With zero latency the accept edge is also the commit edge, so commit from live inputs.
    if (state_q == StIdle) begin
      c_addr = Addr;
      c_data = DataIn;
      c_rd   = RD;
      c_wr   = WR;
    end else begin
      c_addr = addr_q;
      c_data = data_q;
      c_rd   = rd_q;
      c_wr   = wr_q;
    end
    commit = (accept && (LATENCY == 0)) || ((state_q == StWait) && (cnt_q == 4'd1));
    c_err  = ((32'(c_addr) >> DEPTH_LOG2) != 32'd0) || (c_rd && c_wr);
    c_idx  = c_addr[DEPTH_LOG2-1:0];
  end

  // RAM shares the reset block only so a held reset blocks writes; it is never cleared.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      DataOut <= 16'h0000;
      Ready   <= 1'b0;
      Err     <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      Ready <= 1'b0;
      Err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q  <= Addr;
            data_q  <= DataIn;
            rd_q    <= RD;
            wr_q    <= WR;
            cnt_q   <= 4'(LATENCY);
            state_q <= (LATENCY == 0) ? StDone : StWait;
            Busy    <= 1'b1;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
          Busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
      if (commit) begin
        Ready <= 1'b1;
        Err   <= c_err;
        if (c_err) begin
          DataOut <= 16'h0000;
        end else if (c_rd) begin
          DataOut <= ram[c_idx];
        end else if (c_wr) begin
          ram[c_idx] <= c_data;
        end
      end
    end
  end

endmodule
